seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Multiplexed N-digit 7-segment display driver. It scans `DIGITS` common-anode digits in time-division fashion and decodes each 4-bit nibble to full hexadecimal (0–F). Frame-synchronous double buffering ensures a displayed frame never mixes old and new values. It sits between the numeric datapath and the board's segment and anode pins, replacing the single-digit combinational decoder.

## Interface
Parameters:
- `DIGITS`, 4, number of scanned digits; legal range 1..8.
- `CLK_DIV`, 50000, clock cycles each digit is lit; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  0: display dark, scan frozen.
- `seg7all_on`  in  1  lamp test: all segments and dp lit on scanned digits.
- `value`  in  4*DIGITS  nibble k drives digit k; digit 0 is the least significant.
- `dp_in`  in  DIGITS  decimal point per digit, active-high.
- `load`  in  1  1-cycle strobe; captures `value` and `dp_in`.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  DIGITS  digit select, active-low, one-hot-low while scanning.

## Operation
- **Prescaler `cnt`** (width `$clog2(CLK_DIV)`): counts 0..CLK_DIV-1 and wraps. `tick` = (`cnt` == CLK_DIV-1).
- **Scan index `idx`** (width max(1, `$clog2(DIGITS)`)): increments on `tick` and wraps DIGITS-1 → 0. `frame_end` = `tick` && `idx` == DIGITS-1.
- **enable = 0:**
  - `cnt` and `idx` are forced to 0.
  - `an` is all 1, `seg` = 7'h7F, `dp` = 1.
- **Buffering:**
  - `load` writes `pend` ← {`value`, `dp_in`} and sets `pend_v`.
  - Transfer `disp` ← `pend` and clear `pend_v` when `pend_v` && (`frame_end` || !`enable`).
  - `load` in the same cycle as a transfer: the old `pend` transfers, the new data goes to `pend`, and `pend_v` stays 1.
  - Repeated `load` before a transfer: the last load wins.
- **Decode** of `disp` nibble[`idx`] (gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- `dp` = ~`disp_dp`[`idx`].
- **Priority:** `rst` > !`enable` > `seg7all_on` (`seg` = 0, `dp` = 0; `an` keeps scanning) > normal decode.

## Timing
- **Reset values:** `cnt` = 0, `idx` = 0, `disp` = 0, `pend` = 0, `pend_v` = 0, `seg` = 7'h7F, `dp` = 1, `an` = all 1.
- `seg`, `dp` and `an` are registered. They reflect `idx`, `disp`, `enable` and `seg7all_on` with 1-cycle latency, and `seg` and `an` change on the same edge.
- Each digit is lit for exactly CLK_DIV cycles. One frame = DIGITS*CLK_DIV cycles.
- **Load-to-display latency:**
  - enable = 1: ≤ DIGITS*CLK_DIV + 1 cycles, with the first new frame starting at digit 0.
  - enable = 0: the transfer happens on the next edge.
- **rst mid-frame:** discards `pend`. Outputs go dark on the next edge, and the scan restarts at digit 0.
- **enable deasserted mid-frame:** the scan is discarded. On reassertion, digit 0 is lit for a full CLK_DIV.
- **DIGITS = 1:** `idx` is constant 0 and `frame_end` = `tick`.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined: leading zero digits are blanked (`seg` = 7'h7F).
  - A leading zero is a digit k ≥ 1 whose nibble and all nibbles above it are 0.
  - Digit 0 is never blanked.
  - `dp` still follows `dp_in`.
  - Lamp test overrides blanking.
- Not defined: every digit is decoded. The blanking logic is absent.

## Test plan
- **Reset:** DIGITS = 4, CLK_DIV = 4; assert `rst` 3 cycles with `enable` = 1 → `seg` = 7'h7F, `dp` = 1, `an` = 4'b1111. One cycle after release, `an` = 4'b1110 and `seg` = 1000000.
- **Scan and decode:** `load` 16'h1234 with `dp_in` = 4'b0100.
  - After `frame_end`, digit 0 shows 0011001 (4) and `an` = 1110.
  - Each digit dwells 4 cycles: 0110000, then 0100100 with `dp` = 0, then 1111001.
  - `an` wraps back to 1110 after 16 cycles.
- **Hex and double buffer:** `load` 16'hABCD mid-frame, then 16'hEF00 two cycles later → the current frame is unchanged. The next frame shows only EF00: digit 3 = 0000110, digit 2 = 0001110.
- **Enable and lamp test:**
  - `enable` = 0 → `an` = 1111 after 1 cycle.
  - `load` 16'h0009 while disabled → visible in the first lit cycle after re-enable.
  - `seg7all_on` = 1 → `seg` = 0 and `dp` = 0 while `an` still scans.
- **`SEG7_LEADING_ZERO_BLANK_EN`:**
  - `load` 16'h0050 → digits 3 and 2 = 7'h7F, digit 1 = 0010010, digit 0 = 1000000.
  - `load` 16'h0000 → only digit 0 is lit.
- **Reset mid-operation:** `load` then `rst` before `frame_end` → the display stays 0000 and `pend_v` = 0 after release.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit hex 7-segment driver with frame-synchronous double buffering.
// Optional leading-zero blanking via `define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  seg7all_on,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                frame_end;
    logic                xfer;

    logic [4*DIGITS-1:0] disp_val;
    logic [DIGITS-1:0]   disp_dp;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_v;

    logic [3:0]          nib;
    logic                dsel;
    logic                blank;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          glyph;

    assign tick      = (cnt == CNT_MAX);
    assign frame_end = tick && (idx == IDX_MAX);
    // While dark there is no frame to tear, so pending data moves immediately.
    assign xfer      = pend_v && (frame_end || !enable);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_v   <= 1'b0;
        end else begin
            if (xfer) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_v   <= 1'b1;
            end else if (xfer) begin
                pend_v   <= 1'b0;
            end
        end
    end

    always_comb begin
        nib     = 4'h0;
        dsel    = 1'b0;
        an_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib        = disp_val[4*k +: 4];
                dsel       = disp_dp[k];
                an_next[k] = 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] zero_up;

    // zero_up[k]: nibble k and every nibble above it are zero.
    always_comb begin
        zero_up = '0;
        zero_up[DIGITS-1] = (disp_val[4*DIGITS-1 -: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zero_up[k] = zero_up[k+1] && (disp_val[4*k +: 4] == 4'h0);
        end
        blank = 1'b0;
        for (int k = 1; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                blank = zero_up[k];
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        glyph = 7'h7F;
        unique case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0011000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            an <= an_next;
            if (seg7all_on) begin
                seg <= 7'h00;
                dp  <= 1'b0;
            end else begin
                seg <= blank ? 7'h7F : glyph;
                dp  <= ~dsel;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed steps plus random traffic against a frame-position model.
module tb_seg7_scan_mux;

    localparam int D = 4;
    localparam int C = 4;
    localparam int F = D * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        seg7all_on = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    seg7_scan_mux #(.DIGITS(D), .CLK_DIV(C)) dut (
        .clk(clk), .rst(rst), .enable(enable), .seg7all_on(seg7all_on),
        .value(value), .dp_in(dp_in), .load(load),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    logic [6:0] lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    // Model state: position inside the frame plus shown / pending buffers.
    int          pos = 0;
    logic [15:0] m_val = '0, p_val = '0;
    logic [3:0]  m_dp = '0, p_dp = '0;
    bit          p_v = 0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [3:0]  e_an = 4'hF;

    task automatic model_edge();
        int dg;
        logic [15:0] sh;
        bit blank;
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
            pos = 0; m_val = '0; m_dp = '0; p_val = '0; p_dp = '0; p_v = 0;
            return;
        end
        dg = pos / C;
        sh = m_val >> (4 * dg);
        blank = BLANK_EN && dg >= 1 && sh == 16'h0;
        if (!enable) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end else begin
            e_an = ~(4'(1) << dg);
            if (seg7all_on) begin
                e_seg = 7'h00; e_dp = 1'b0;
            end else begin
                e_seg = blank ? 7'h7F : lut[sh[3:0]];
                e_dp = ~m_dp[dg];
            end
        end
        if (p_v && (!enable || pos == F - 1)) begin
            m_val = p_val; m_dp = p_dp; p_v = 0;
        end
        if (load) begin
            p_val = value; p_dp = dp_in; p_v = 1;
        end
        pos = enable ? (pos + 1) % F : 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model_out", {20'h0, seg, dp, an}, {20'h0, e_seg, e_dp, e_an});
    endtask

    task automatic wait_for(input string tag, input logic [3:0] a, input logic [6:0] s, input int lim);
        bit found = 0;
        for (int i = 0; i < lim; i++) begin
            cyc();
            if (an === a && seg === s) begin
                found = 1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        int bad;
        // Reset
        repeat (3) cyc();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_an", 32'(an), 32'hF);
        rst = 1'b0;
        cyc();
        check("rel_an", 32'(an), 32'b1110);
        check("rel_seg", 32'(seg), 32'b1000000);

        // Scan and decode
        do_load(16'h1234, 4'b0100);
        wait_for("scan_d0", 4'b1110, 7'b0011001, F + 2);
        repeat (C) cyc();
        check("scan_d1", {seg, dp, an}, {7'b0110000, 1'b1, 4'b1101});
        repeat (C) cyc();
        check("scan_d2", {seg, dp, an}, {7'b0100100, 1'b0, 4'b1011});
        repeat (C) cyc();
        check("scan_d3", {seg, dp, an}, {7'b1111001, 1'b1, 4'b0111});
        repeat (C) cyc();
        check("scan_wrap", {seg, an}, {7'b0011001, 4'b1110});

        // Hex and double buffer
        repeat (5) cyc();
        do_load(16'hABCD, 4'b0000);
        cyc();
        do_load(16'hEF00, 4'b0000);
        wait_for("db_d2", 4'b1011, 7'b0001110, 2 * F);
        repeat (C) cyc();
        check("db_d3", {seg, an}, {7'b0000110, 4'b0111});

        // Enable and lamp test
        enable = 1'b0;
        cyc();
        check("dis_an", 32'(an), 32'hF);
        do_load(16'h0009, 4'b0000);
        cyc();
        enable = 1'b1;
        cyc();
        check("reen_d0", {seg, an}, {7'b0011000, 4'b1110});
        seg7all_on = 1'b1;
        repeat (3) cyc();
        check("lamp_seg", {seg, dp}, 8'h00);
        repeat (C) cyc();
        check("lamp_scan", 32'(an != 4'hF), 32'd1);
        seg7all_on = 1'b0;

        // Leading zero blanking (or plain decode when disabled)
        do_load(16'h0050, 4'b0000);
        repeat (2 * F) cyc();
        wait_for("lz_sync", 4'b0111, BLANK_EN ? 7'h7F : 7'b1000000, F + 1);
        repeat (C) cyc();
        check("lz_d0", {seg, an}, {7'b1000000, 4'b1110});
        repeat (C) cyc();
        check("lz_d1", {seg, an}, {7'b0010010, 4'b1101});
        repeat (C) cyc();
        check("lz_d2", {seg, an}, {BLANK_EN ? 7'h7F : 7'b1000000, 4'b1011});
        do_load(16'h0000, 4'b0000);
        repeat (2 * F) cyc();
        bad = 0;
        for (int i = 0; i < F; i++) begin
            cyc();
            if (an === 4'b1110 && seg !== 7'b1000000) bad++;
            if (an !== 4'b1110 && seg !== (BLANK_EN ? 7'h7F : 7'b1000000)) bad++;
        end
        check("lz_zero", 32'(bad), 32'd0);

        // Reset mid-frame discards pending data
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();
        do_load(16'h1234, 4'b1111);
        cyc();
        rst = 1'b1;
        cyc();
        check("mid_rst_dark", 32'(an), 32'hF);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 2 * F; i++) begin
            cyc();
            if (seg !== 7'b1000000 || dp !== 1'b1) bad++;
        end
        check("mid_rst_zero", 32'(bad), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(59) == 0);
            enable = ($urandom_range(7) != 0);
            seg7all_on = ($urandom_range(9) == 0);
            load = ($urandom_range(5) == 0);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            cyc();
        end
        rst = 1'b0; load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
